// File: rtl/sr4_ctrl_pkg.sv
// sr4_ctrl_pkg: shared state encoding and default sizes for the shift-register load controller.
package sr4_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2;
  localparam int WL_W = 8;
endpackage

// File: rtl/sr4_word_fifo.sv
// sr4_word_fifo: synchronous word FIFO with registered count; pointers wrap modulo DEPTH.
module sr4_word_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/sr4_load_ctrl.sv
// sr4_load_ctrl: buffers words and paces load/shift of a WIDTH-bit shift register.
// SR4_LOAD_CTRL_CNT_EN adds an 8-bit wrapping count of load pulses on words_loaded.
module sr4_load_ctrl
  import sr4_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fill,
  output logic [WIDTH-1:0] R,
  output logic             L,
  output logic             w,
  output logic             busy
`ifdef SR4_LOAD_CTRL_CNT_EN
  ,
  output logic [WL_W-1:0]  words_loaded
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [SW-1:0]    sc_q, sc_d;
  logic [WIDTH-1:0] r_q, r_d, head;
  logic             l_q, l_d, w_q, full, empty, push, pop, nonempty, last, next_ld;
  logic [CW-1:0]    cnt;
  assign push     = in_valid && in_ready;
  assign pop      = state_q == LOAD;
  assign in_ready = !full;
  assign busy     = !empty || state_q != IDLE;
  assign R        = r_q;
  assign L        = l_q;
  assign w        = w_q;
  sr4_word_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_data),
    .dout_o  (head),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );
  // the reload decision on the last shift cycle keeps loads exactly WIDTH cycles apart
  always_comb begin
    nonempty = cnt != '0;
    last     = sc_q == SW'(WIDTH - 2);
    next_ld  = state_q == IDLE ? nonempty : (state_q == SHIFT && last && nonempty);
    state_d  = state_q == LOAD ? SHIFT : next_ld ? LOAD : (state_q == SHIFT && !last) ? SHIFT : IDLE;
    sc_d     = state_q == SHIFT ? sc_q + SW'(1) : '0;
    l_d      = state_d == LOAD;
    r_d      = l_d ? head : r_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sc_q    <= '0;
      l_q     <= 1'b0;
      r_q     <= '0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      l_q     <= l_d;
      r_q     <= r_d;
      w_q     <= fill;
    end
  end
`ifdef SR4_LOAD_CTRL_CNT_EN
  logic [WL_W-1:0] wl_q;
  assign words_loaded = wl_q;
  always_ff @(posedge clk)
    if (reset) wl_q <= '0;
    else wl_q <= wl_q + WL_W'(l_q);
`endif
endmodule

// File: doc/sr4_load_ctrl.md
# sr4_load_ctrl

Upstream pacing stage for the 4-bit shift register: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and drives the register's parallel-load, load-strobe and serial-input lines. Each word is loaded once and then shifted out for exactly WIDTH cycles before the next load, so back-to-back words stream without gaps or overlap. It sits between the word producer and the shift register on the same clock.

## Interface
- WIDTH, default 4: shift-register width; also the load-to-load period in cycles.
- DEPTH, default 2: FIFO entries; power of two, minimum 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  word to load.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word this cycle.
- fill  in  1  serial fill bit fed to the register during shifting.
- R  out  WIDTH  parallel-load value to the register.
- L  out  1  load strobe to the register; high for exactly one cycle per word.
- w  out  1  serial input to the register.
- busy  out  1  high while the FIFO is non-empty or the FSM is not IDLE.

## Operation
- Push: in_valid && in_ready at an edge writes in_data at the tail.
- in_ready = (count < DEPTH), from registered state only; no combinational path from in_valid.
- When full, in_ready = 0 even if a pop occurs in the same cycle; a push is never accepted into a full FIFO.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: L = 0. If count != 0, go to LOAD at the next edge.
  - LOAD: L = 1, R = head word. Pop on this edge. Shift counter = 0. Next state is SHIFT.
  - SHIFT: L = 0, R holds its last value. The counter increments each cycle. At counter = WIDTH-2, i.e. the (WIDTH-1)th shift cycle, go to LOAD if the FIFO is non-empty, otherwise to IDLE.
- L, R and w are registered outputs.
- w = fill, delayed by one cycle, in every state.
- A push and a pop in the same cycle leave count unchanged.
- Head/tail pointers wrap modulo DEPTH.
- Reset mid-operation discards the FIFO contents and any word in flight, with no partial L pulse.

## Timing
- Reset values: L = 0, R = 0, w = 0, in_ready = 1 (count = 0), busy = 0, state IDLE, pointers 0.
- Latency: a word accepted at edge t into an empty FIFO while IDLE gives L = 1 and R = word in the cycle after edge t+1. The register captures it at edge t+2.
- Back-to-back throughput: with the FIFO never empty, consecutive L pulses are exactly WIDTH cycles apart.
- After the last word, busy falls in the cycle the FSM re-enters IDLE: WIDTH cycles after that word's L pulse.
- in_ready rises the cycle after the pop that frees a slot.

## Configuration
- SR4_LOAD_CTRL_CNT_EN defined:
  - adds output port words_loaded [7:0];
  - increments on every cycle L = 1 and wraps from 255 to 0;
  - resets to 0.
- SR4_LOAD_CTRL_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package sr4_ctrl_pkg holds:
  - the state enum typedef (IDLE, LOAD, SHIFT);
  - default constants for WIDTH (4) and DEPTH (2);
  - the words_loaded width (8).
- Sub-module sr4_word_fifo: synchronous FIFO with push/pop, data out, count, full and empty. The FSM and the output registers stay in sr4_load_ctrl.

## Test plan
All cases use WIDTH=4, DEPTH=2.
- Reset, then idle for 10 cycles -> L = 0, R = 0, w = 0, in_ready = 1, busy = 0 throughout.
- Push 4'b0010 at edge 3 -> L = 1 with R = 4'b0010 for one cycle after edge 4 only. busy falls 4 cycles after the L pulse.
- Push 4'hA, 4'h5, 4'hC back-to-back with in_valid held -> in_ready drops to 0 after the second push. L pulses at cycles n, n+4, n+8 carry A, 5, C, with no duplicate or missing pulse.
- fill toggled every cycle -> w equals fill delayed by exactly one cycle in IDLE, LOAD and SHIFT.
- Assert reset during the SHIFT of the first of two queued words -> the next cycle has L = 0, count = 0 and busy = 0, and the queued word is never loaded.
- SR4_LOAD_CTRL_CNT_EN defined, 257 words streamed -> words_loaded reads 1 after the final L pulse (wrap verified).
